// File: rtl/prog_loader.sv
// Boot loader: byte stream -> 16-bit words -> imem, CPU held in reset until done.
// Ports: clk/reset, rx_valid/rx_data/rx_ready byte sink, imem_we/addr/wdata, cpu_reset/done/error. Option: LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int n      = 16,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [n-1:0]      imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] S_LEN_HI  = 3'd0;
  localparam logic [2:0] S_LEN_LO  = 3'd1;
  localparam logic [2:0] S_DATA_HI = 3'd2;
  localparam logic [2:0] S_DATA_LO = 3'd3;
  localparam logic [2:0] S_FLUSH   = 3'd4;
  localparam logic [2:0] S_RUN     = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM    = 3'd7;
  localparam logic [2:0] S_END     = S_CSUM;
`else
  localparam logic [2:0] S_END     = S_FLUSH;
`endif

  localparam logic [15:0] MAX_WORDS = 16'(2 ** ADDR_W);

  logic [2:0]        state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [n-1:0]      wdata_q, wdata_d;
  logic              rdy_q, rdy_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        xfer;
  logic [15:0] len_w;

  assign xfer  = rx_valid && rdy_q;
  assign len_w = {hi_q, rx_data};

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    rem_d   = rem_q;
    wcnt_d  = wcnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      S_LEN_HI: begin
        if (xfer) begin
          hi_d    = rx_data;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          if (len_w > MAX_WORDS) begin
            state_d = S_ERROR;
          end else if (len_w == 16'd0) begin
            state_d = S_END;
          end else begin
            rem_d   = len_w[ADDR_W:0];
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (xfer) begin
          hi_d    = rx_data;
          state_d = S_DATA_LO;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q + rx_data;
`endif
        end
      end
      S_DATA_LO: begin
        if (xfer) begin
          we_d    = 1'b1;
          addr_d  = wcnt_q;
          wdata_d = n'({hi_q, rx_data});
          // Wraps only after the 128th word, when no writes remain.
          wcnt_d  = wcnt_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == 1) ? S_END : S_DATA_HI;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q + rx_data;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          state_d = (rx_data == csum_q) ? S_FLUSH : S_ERROR;
        end
      end
`endif
      S_FLUSH: state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  // Status outputs are registered from the next state so they line up
  // with the state they describe.
  always_comb begin
    rdy_d     = (state_d == S_LEN_HI)  || (state_d == S_LEN_LO) ||
                (state_d == S_DATA_HI) || (state_d == S_DATA_LO)
`ifdef LOADER_CHECKSUM_EN
                || (state_d == S_CSUM)
`endif
                ;
    cpu_rst_d = (state_d != S_RUN);
    done_d    = (state_d == S_RUN);
    err_d     = (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_LEN_HI;
      hi_q      <= '0;
      rem_q     <= '0;
      wcnt_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdy_q     <= 1'b1;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      rem_q     <= rem_d;
      wcnt_q    <= wcnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdy_q     <= rdy_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign rx_ready   = rdy_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = cpu_rst_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader.
// Streams byte images and checks imem writes and status outputs.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        imem_we;
  logic [6:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int tests = 0;
  int fails = 0;
  int stalls = 0;
  logic [7:0] sum = 8'h00;

  logic [6:0]  q_addr[$];
  logic [15:0] q_data[$];

`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      q_addr.push_back(imem_addr);
      q_data.push_back(imem_wdata);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    q_addr.delete();
    q_data.delete();
    stalls = 0;
    sum = 8'h00;
  endtask

  // Offer one byte; returns just after the accepting edge.
  task automatic send(input logic [7:0] b, input int gap);
    int w;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    w = 0;
    while (rx_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    stalls += w;
    if (w >= 20) begin
      tests++;
      fails++;
      $display("FAIL send_timeout byte=%h", b);
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_data(input logic [7:0] b, input int gap);
    sum = sum + b;
    send(b, gap);
  endtask

  task automatic send_csum(input int gap);
    if (CSUM) send(sum, gap);
  endtask

  task automatic send_img3(input int gap);
    send(8'h00, gap);
    send(8'h03, gap);
    send_data(8'h12, gap);
    send_data(8'h34, gap);
    send_data(8'hAB, gap);
    send_data(8'hCD, gap);
    send_data(8'h00, gap);
    send_data(8'h01, gap);
  endtask

  task automatic check_img3(input string tag);
    tests++;
    if (q_addr.size() !== 3) begin
      fails++;
      $display("FAIL %s_nwr got=%0d exp=3", tag, q_addr.size());
    end
    if (q_addr.size() == 3) begin
      tests++;
      if (q_addr[0] !== 7'd0 || q_data[0] !== 16'h1234) begin
        fails++;
        $display("FAIL %s_w0 got=%0d:%h exp=0:1234", tag, q_addr[0], q_data[0]);
      end
      tests++;
      if (q_addr[1] !== 7'd1 || q_data[1] !== 16'hABCD) begin
        fails++;
        $display("FAIL %s_w1 got=%0d:%h exp=1:abcd", tag, q_addr[1], q_data[1]);
      end
      tests++;
      if (q_addr[2] !== 7'd2 || q_data[2] !== 16'h0001) begin
        fails++;
        $display("FAIL %s_w2 got=%0d:%h exp=2:0001", tag, q_addr[2], q_data[2]);
      end
    end
  endtask

  // Called right after the final byte is accepted: one FLUSH cycle, then RUN.
  task automatic check_finish(input string tag);
    @(negedge clk);
    tests++;
    if (rx_ready !== 1'b0 || done !== 1'b0 || cpu_reset !== 1'b1) begin
      fails++;
      $display("FAIL %s_flush rdy/done/crst got=%b%b%b exp=001",
               tag, rx_ready, done, cpu_reset);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0 ||
        rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s_run done/crst/err/rdy got=%b%b%b%b exp=1000",
               tag, done, cpu_reset, error, rx_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++;
    if (rx_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_ready got=%b exp=1", rx_ready);
    end
    tests++;
    if (imem_we !== 1'b0 || imem_addr !== 7'd0 || imem_wdata !== 16'h0) begin
      fails++;
      $display("FAIL rst_imem got=%b/%0d/%h exp=0/0/0000",
               imem_we, imem_addr, imem_wdata);
    end
    tests++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL rst_status crst/done/err got=%b%b%b exp=100",
               cpu_reset, done, error);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_img3(0);
    send_csum(0);
    check_finish("b2b");
    check_img3("b2b");
    tests++;
    if (stalls !== 0) begin
      fails++;
      $display("FAIL b2b_stalls got=%0d exp=0", stalls);
    end
    // Bytes offered in RUN are ignored.
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = 8'h55;
    repeat (4) @(negedge clk);
    rx_valid = 1'b0;
    tests++;
    if (q_addr.size() !== 3 || done !== 1'b1) begin
      fails++;
      $display("FAIL run_ignore nwr=%0d done=%b exp=3/1", q_addr.size(), done);
    end
  endtask

  task automatic test_gapped();
    do_reset();
    send_img3(1);
    send_csum(1);
    repeat (3) @(negedge clk);
    check_img3("gap");
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL gap_done got=%b exp=1", done);
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    send(8'h00, 0);
    send(8'h00, 0);
    send_csum(0);
    check_finish("zero");
    tests++;
    if (q_addr.size() !== 0) begin
      fails++;
      $display("FAIL zero_nwr got=%0d exp=0", q_addr.size());
    end
  endtask

  task automatic test_overlong();
    do_reset();
    send(8'h00, 0);
    send(8'h81, 0);
    @(negedge clk);
    tests++;
    if (error !== 1'b1 || rx_ready !== 1'b0 || cpu_reset !== 1'b1 ||
        done !== 1'b0) begin
      fails++;
      $display("FAIL long_err err/rdy/crst/done got=%b%b%b%b exp=1010",
               error, rx_ready, cpu_reset, done);
    end
    rx_valid = 1'b1;
    rx_data = 8'h12;
    repeat (4) @(negedge clk);
    rx_valid = 1'b0;
    tests++;
    if (q_addr.size() !== 0 || error !== 1'b1) begin
      fails++;
      $display("FAIL long_nowr nwr=%0d err=%b exp=0/1", q_addr.size(), error);
    end
  endtask

  task automatic test_max_len();
    int bad;
    do_reset();
    send(8'h00, 0);
    send(8'h80, 0);
    for (int i = 0; i < 128; i++) begin
      send_data(8'(i), 0);
      send_data(~8'(i), 0);
    end
    send_csum(0);
    check_finish("max");
    tests++;
    if (q_addr.size() !== 128) begin
      fails++;
      $display("FAIL max_nwr got=%0d exp=128", q_addr.size());
    end
    bad = 0;
    for (int i = 0; i < q_addr.size(); i++) begin
      if (q_addr[i] !== 7'(i) || q_data[i] !== {8'(i), ~8'(i)}) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL max_words bad=%0d exp=0", bad);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'h12, 0);
    // Reset wins over a byte transfer on the same edge.
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h34;
    @(negedge clk);
    reset = 1'b0;
    rx_valid = 1'b0;
    tests++;
    if (rx_ready !== 1'b1 || imem_we !== 1'b0 || cpu_reset !== 1'b1) begin
      fails++;
      $display("FAIL mid_rst rdy/we/crst got=%b%b%b exp=101",
               rx_ready, imem_we, cpu_reset);
    end
    sum = 8'h00;
    send(8'h00, 0);
    send(8'h01, 0);
    send_data(8'hBE, 0);
    send_data(8'hEF, 0);
    send_csum(0);
    check_finish("mid");
    tests++;
    if (q_addr.size() !== 1 || q_data[0] !== 16'hBEEF ||
        q_addr[0] !== 7'd0) begin
      fails++;
      $display("FAIL mid_wr nwr=%0d w0=%0d:%h exp=1 0:beef",
               q_addr.size(), q_addr[0], q_data[0]);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    send_img3(0);
    send(8'hBF, 0);
    check_finish("csum_ok");
    check_img3("csum_ok");
    do_reset();
    send_img3(0);
    send(8'hC0, 0);
    repeat (2) @(negedge clk);
    check_img3("csum_bad");
    tests++;
    if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL csum_bad err/crst/done got=%b%b%b exp=110",
               error, cpu_reset, done);
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_zero_len();
    test_overlong();
    test_max_len();
    test_mid_reset();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
